// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types and field positions for the joint TLB.
//   - CP0 TLB operation encodings
//   - EntryLo bit positions
//   - sequencer state encoding
//   - stored entry layout (ASID/PFN held at their widest field width)
package tlb_pkg;

   typedef enum logic [1:0] {
      OP_TLBP  = 2'b00,
      OP_TLBR  = 2'b01,
      OP_TLBWI = 2'b10,
      OP_TLBWR = 2'b11
   } tlb_op_e;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'b00,
      SEQ_EXEC = 2'b01,
      SEQ_DONE = 2'b10
   } seq_state_e;

   // EntryLo layout: {PFN[25:6], C[5:3], D[2], V[1], G[0]}
   localparam int unsigned LO_G      = 0;
   localparam int unsigned LO_V      = 1;
   localparam int unsigned LO_D      = 2;
   localparam int unsigned LO_C_LSB  = 3;
   localparam int unsigned LO_PFN_LSB = 6;
   localparam int unsigned LO_PFN_MSB = 25;

   localparam int unsigned VPN2_W       = 19;  // entryhi[31:13]
   localparam int unsigned ASID_FIELD_W = 13;  // entryhi[12:0]
   localparam int unsigned PFN_FIELD_W  = 20;  // entrylo[25:6]
   localparam int unsigned FLAGS_W      = 5;   // {C[2:0],D,V}

   // Bit positions inside a flags word {C,D,V}
   localparam int unsigned FL_V = 0;
   localparam int unsigned FL_D = 1;

   typedef struct packed {
      logic [VPN2_W-1:0]       vpn2;
      logic [ASID_FIELD_W-1:0] asid;
      logic                    g;
      logic                    valid;
      logic [PFN_FIELD_W-1:0]  pfn0;
      logic [FLAGS_W-1:0]      flags0;
      logic [PFN_FIELD_W-1:0]  pfn1;
      logic [FLAGS_W-1:0]      flags1;
   } tlb_entry_t;

   function automatic logic [FLAGS_W-1:0] lo_flags(input logic [31:0] lo);
      return lo[LO_C_LSB+2:LO_V];
   endfunction

endpackage

// File: rtl/tlb_match.sv
// tlb_match: combinational fully associative compare plus priority encode.
//   entries_i : all TLB entries
//   vpn2_i    : VPN2 of the address being translated
//   asid_i    : current ASID (already masked to the configured width)
//   match_o   : some valid entry matches
//   index_o   : lowest matching index (0 when no match)
module tlb_match
   import tlb_pkg::*;
#(
   parameter  int unsigned NUM_ENTRIES = 16,
   localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  tlb_entry_t [NUM_ENTRIES-1:0] entries_i,
   input  logic [VPN2_W-1:0]            vpn2_i,
   input  logic [ASID_FIELD_W-1:0]      asid_i,
   output logic                         match_o,
   output logic [IDX_W-1:0]             index_o
);

   always_comb begin
      match_o = 1'b0;
      index_o = '0;
      for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
         if (!match_o && entries_i[k].valid && entries_i[k].vpn2 == vpn2_i &&
             (entries_i[k].g || entries_i[k].asid == asid_i)) begin
            match_o = 1'b1;
            index_o = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/tlb_mmu.sv
// tlb_mmu: parametrised fully associative joint TLB.
//   clk_i/rst_i          : clock, async active-high reset
//   ireq_i/iva_i         : instruction lookup -> ihit_o/ipa_o/iflags_o (registered)
//   dreq_i/dva_i/dwrite_i: data lookup -> dhit_o/dpa_o/dflags_o/dmod_o (registered)
//   op_valid_i/op_i      : CP0 TLBP/TLBR/TLBWI/TLBWR request; op_ready_o, op_done_o
//   entryhi_i/entrylo0_i/entrylo1_i/index_i : CP0 operands (current ASID from entryhi_i)
//   wired_i              : Wired register
//   entryhi_o/entrylo0_o/entrylo1_o : TLBR results; index_o : TLBP result
//   random_o             : Random register
module tlb_mmu
   import tlb_pkg::*;
#(
   parameter  int unsigned NUM_ENTRIES = 16,
   parameter  int unsigned ASID_W      = 8,
   parameter  int unsigned PFN_W       = 20,
   localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ireq_i,
   input  logic [31:0]      iva_i,
   output logic             ihit_o,
   output logic [31:0]      ipa_o,
   output logic [4:0]       iflags_o,
   input  logic             dreq_i,
   input  logic [31:0]      dva_i,
   input  logic             dwrite_i,
   output logic             dhit_o,
   output logic [31:0]      dpa_o,
   output logic [4:0]       dflags_o,
   output logic             dmod_o,
   input  logic             op_valid_i,
   input  logic [1:0]       op_i,
   output logic             op_ready_o,
   output logic             op_done_o,
   input  logic [31:0]      entryhi_i,
   input  logic [31:0]      entrylo0_i,
   input  logic [31:0]      entrylo1_i,
   input  logic [IDX_W-1:0] index_i,
   input  logic [IDX_W-1:0] wired_i,
   output logic [31:0]      entryhi_o,
   output logic [31:0]      entrylo0_o,
   output logic [31:0]      entrylo1_o,
   output logic [31:0]      index_o,
   output logic [IDX_W-1:0] random_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
   localparam logic [ASID_FIELD_W-1:0] ASID_MASK = ASID_FIELD_W'((64'd1 << ASID_W) - 64'd1);
   localparam logic [PFN_FIELD_W-1:0]  PFN_MASK  = PFN_FIELD_W'((64'd1 << PFN_W) - 64'd1);

   tlb_entry_t [NUM_ENTRIES-1:0] entries_q, entries_d;
   seq_state_e        state_q, state_d;
   tlb_op_e           op_q, op_d;
   logic [IDX_W-1:0]  random_q, random_d;
   logic              ihit_q, ihit_d, dhit_q, dhit_d, dmod_q, dmod_d;
   logic [31:0]       ipa_q, ipa_d, dpa_q, dpa_d;
   logic [4:0]        iflags_q, iflags_d, dflags_q, dflags_d;
   logic [31:0]       entryhi_q, entryhi_d, entrylo0_q, entrylo0_d;
   logic [31:0]       entrylo1_q, entrylo1_d, index_q, index_d;

   logic [ASID_FIELD_W-1:0] cur_asid;
   logic                    i_match, d_match, p_match;
   logic [IDX_W-1:0]        i_idx, d_idx, p_idx;
   tlb_entry_t              i_ent, d_ent, r_ent, new_ent;
   logic [PFN_FIELD_W-1:0]  i_pfn, d_pfn;
   logic [4:0]              i_fl, d_fl;
   logic [IDX_W-1:0]        wr_idx;
   logic [11:0]             unused_lo_bits;

   assign unused_lo_bits = {entrylo0_i[31:26], entrylo1_i[31:26]};
   assign cur_asid = entryhi_i[ASID_FIELD_W-1:0] & ASID_MASK;

   tlb_match #(.NUM_ENTRIES(NUM_ENTRIES)) u_imatch (
      .entries_i(entries_q), .vpn2_i(iva_i[31:13]), .asid_i(cur_asid),
      .match_o(i_match), .index_o(i_idx)
   );

   tlb_match #(.NUM_ENTRIES(NUM_ENTRIES)) u_dmatch (
      .entries_i(entries_q), .vpn2_i(dva_i[31:13]), .asid_i(cur_asid),
      .match_o(d_match), .index_o(d_idx)
   );

   tlb_match #(.NUM_ENTRIES(NUM_ENTRIES)) u_pmatch (
      .entries_i(entries_q), .vpn2_i(entryhi_i[31:13]), .asid_i(cur_asid),
      .match_o(p_match), .index_o(p_idx)
   );

   always_comb begin
      i_ent = entries_q[i_idx];
      d_ent = entries_q[d_idx];
      r_ent = entries_q[index_i];
      i_pfn = iva_i[12] ? i_ent.pfn1   : i_ent.pfn0;
      i_fl  = iva_i[12] ? i_ent.flags1 : i_ent.flags0;
      d_pfn = dva_i[12] ? d_ent.pfn1   : d_ent.pfn0;
      d_fl  = dva_i[12] ? d_ent.flags1 : d_ent.flags0;

      new_ent.vpn2   = entryhi_i[31:13];
      new_ent.asid   = cur_asid;
      new_ent.g      = entrylo0_i[LO_G] & entrylo1_i[LO_G];
      new_ent.valid  = 1'b1;
      new_ent.pfn0   = entrylo0_i[LO_PFN_MSB:LO_PFN_LSB] & PFN_MASK;
      new_ent.flags0 = lo_flags(entrylo0_i);
      new_ent.pfn1   = entrylo1_i[LO_PFN_MSB:LO_PFN_LSB] & PFN_MASK;
      new_ent.flags1 = lo_flags(entrylo1_i);

      // random_q during EXEC is the value sampled at the start of EXEC
      wr_idx = (op_q == OP_TLBWR) ? random_q : index_i;
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      entries_d  = entries_q;
      ihit_d     = ihit_q;
      ipa_d      = ipa_q;
      iflags_d   = iflags_q;
      dhit_d     = dhit_q;
      dpa_d      = dpa_q;
      dflags_d   = dflags_q;
      dmod_d     = dmod_q;
      entryhi_d  = entryhi_q;
      entrylo0_d = entrylo0_q;
      entrylo1_d = entrylo1_q;
      index_d    = index_q;

      if (ireq_i) begin
         ihit_d   = i_match;
         ipa_d    = i_match ? {i_pfn, iva_i[11:0]} : '0;
         iflags_d = i_match ? i_fl : '0;
      end
      if (dreq_i) begin
         dhit_d   = d_match;
         dpa_d    = d_match ? {d_pfn, dva_i[11:0]} : '0;
         dflags_d = d_match ? d_fl : '0;
         dmod_d   = dwrite_i && d_match && d_fl[FL_V] && !d_fl[FL_D];
      end

      case (state_q)
         SEQ_IDLE: begin
            if (op_valid_i) begin
               op_d    = tlb_op_e'(op_i);
               state_d = SEQ_EXEC;
            end
         end
         SEQ_EXEC: begin
            state_d = SEQ_DONE;
            case (op_q)
               OP_TLBP: index_d = p_match ? 32'(p_idx) : 32'h8000_0000;
               OP_TLBR: begin
                  entryhi_d  = {r_ent.vpn2, r_ent.asid};
                  entrylo0_d = {6'b0, r_ent.pfn0, r_ent.flags0, r_ent.g};
                  entrylo1_d = {6'b0, r_ent.pfn1, r_ent.flags1, r_ent.g};
               end
               default: entries_d[wr_idx] = new_ent;
            endcase
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   always_comb begin
      if (wired_i >= LAST_IDX || random_q <= wired_i) random_d = LAST_IDX;
      else random_d = random_q - IDX_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         entries_q  <= '0;
         state_q    <= SEQ_IDLE;
         op_q       <= OP_TLBP;
         random_q   <= LAST_IDX;
         ihit_q     <= 1'b0;
         ipa_q      <= '0;
         iflags_q   <= '0;
         dhit_q     <= 1'b0;
         dpa_q      <= '0;
         dflags_q   <= '0;
         dmod_q     <= 1'b0;
         entryhi_q  <= '0;
         entrylo0_q <= '0;
         entrylo1_q <= '0;
         index_q    <= '0;
      end else begin
         entries_q  <= entries_d;
         state_q    <= state_d;
         op_q       <= op_d;
         random_q   <= random_d;
         ihit_q     <= ihit_d;
         ipa_q      <= ipa_d;
         iflags_q   <= iflags_d;
         dhit_q     <= dhit_d;
         dpa_q      <= dpa_d;
         dflags_q   <= dflags_d;
         dmod_q     <= dmod_d;
         entryhi_q  <= entryhi_d;
         entrylo0_q <= entrylo0_d;
         entrylo1_q <= entrylo1_d;
         index_q    <= index_d;
      end
   end

   assign ihit_o     = ihit_q;
   assign ipa_o      = ipa_q;
   assign iflags_o   = iflags_q;
   assign dhit_o     = dhit_q;
   assign dpa_o      = dpa_q;
   assign dflags_o   = dflags_q;
   assign dmod_o     = dmod_q;
   assign op_ready_o = (state_q == SEQ_IDLE);
   assign op_done_o  = (state_q == SEQ_DONE);
   assign entryhi_o  = entryhi_q;
   assign entrylo0_o = entrylo0_q;
   assign entrylo1_o = entrylo1_q;
   assign index_o    = index_q;
   assign random_o   = random_q;

endmodule

// File: tb/tb_tlb_mmu.sv
// tb_tlb_mmu: directed plus randomized checks of tlb_mmu against an
// array-based model of the TLB contents, lookup rule and Random register.
module tb_tlb_mmu;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ireq = 1'b0, dreq = 1'b0, dwrite = 1'b0;
   logic [31:0] iva = '0, dva = '0;
   logic        ihit, dhit, dmod;
   logic [31:0] ipa, dpa;
   logic [4:0]  iflags, dflags;
   logic        op_valid = 1'b0;
   logic [1:0]  op = 2'b00;
   logic        op_ready, op_done;
   logic [31:0] entryhi = '0, entrylo0 = '0, entrylo1 = '0;
   logic [3:0]  index_in = '0, wired = '0;
   logic [31:0] entryhi_out, lo0_out, lo1_out, index_out;
   logic [3:0]  random_out;

   int checks = 0;
   int errors = 0;

   // model state
   bit          m_valid [N];
   logic [31:0] m_hi [N], m_lo0 [N], m_lo1 [N];
   logic [3:0]  m_rand;
   logic        e_ihit = 0, e_dhit = 0, e_dmod = 0;
   logic [31:0] e_ipa = 0, e_dpa = 0;
   logic [4:0]  e_iflags = 0, e_dflags = 0;
   logic [31:0] e_ehi = 0, e_lo0 = 0, e_lo1 = 0, e_index = 0;

   tlb_mmu #(.NUM_ENTRIES(16), .ASID_W(8), .PFN_W(20)) dut (
      .clk_i(clk), .rst_i(rst),
      .ireq_i(ireq), .iva_i(iva), .ihit_o(ihit), .ipa_o(ipa), .iflags_o(iflags),
      .dreq_i(dreq), .dva_i(dva), .dwrite_i(dwrite), .dhit_o(dhit), .dpa_o(dpa),
      .dflags_o(dflags), .dmod_o(dmod),
      .op_valid_i(op_valid), .op_i(op), .op_ready_o(op_ready), .op_done_o(op_done),
      .entryhi_i(entryhi), .entrylo0_i(entrylo0), .entrylo1_i(entrylo1),
      .index_i(index_in), .wired_i(wired),
      .entryhi_o(entryhi_out), .entrylo0_o(lo0_out), .entrylo1_o(lo1_out),
      .index_o(index_out), .random_o(random_out)
   );

   always #5 clk = ~clk;

   // Random register: counts down to Wired, then reloads the top index.
   always @(posedge clk or posedge rst) begin
      if (rst) m_rand <= 4'(N - 1);
      else if (int'(wired) >= N - 1 || m_rand <= wired) m_rand <= 4'(N - 1);
      else m_rand <= m_rand - 4'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_lookup(input logic [31:0] va, output logic hit,
                                        output logic [31:0] pa, output logic [4:0] fl);
      logic [31:0] lo;
      hit = 0; pa = 0; fl = 0;
      for (int k = 0; k < N; k++) begin
         if (!hit && m_valid[k] && m_hi[k][31:13] == va[31:13] &&
             ((m_lo0[k][0] & m_lo1[k][0]) || m_hi[k][7:0] == entryhi[7:0])) begin
            hit = 1;
            lo  = va[12] ? m_lo1[k] : m_lo0[k];
            pa  = {lo[25:6], va[11:0]};
            fl  = lo[5:1];
         end
      end
   endfunction

   function automatic logic [31:0] model_probe(input logic [31:0] hi);
      for (int k = 0; k < N; k++)
         if (m_valid[k] && m_hi[k][31:13] == hi[31:13] &&
             ((m_lo0[k][0] & m_lo1[k][0]) || m_hi[k][7:0] == hi[7:0]))
            return 32'(k);
      return 32'h8000_0000;
   endfunction

   task automatic drive_lookup(input bit ir, input logic [31:0] ia, input bit dr,
                               input logic [31:0] da, input bit dw);
      logic h; logic [31:0] p; logic [4:0] f;
      ireq = ir; iva = ia; dreq = dr; dva = da; dwrite = dw;
      if (ir) begin
         model_lookup(ia, h, p, f);
         e_ihit = h; e_ipa = p; e_iflags = f;
      end
      if (dr) begin
         model_lookup(da, h, p, f);
         e_dhit = h; e_dpa = p; e_dflags = f;
         e_dmod = dw && h && f[0] && !f[1];
      end
   endtask

   task automatic check_lookup(input string tag);
      chk({tag, ".ihit"}, 32'(ihit), 32'(e_ihit));
      chk({tag, ".ipa"}, ipa, e_ipa);
      chk({tag, ".iflags"}, 32'(iflags), 32'(e_iflags));
      chk({tag, ".dhit"}, 32'(dhit), 32'(e_dhit));
      chk({tag, ".dpa"}, dpa, e_dpa);
      chk({tag, ".dflags"}, 32'(dflags), 32'(e_dflags));
      chk({tag, ".dmod"}, 32'(dmod), 32'(e_dmod));
   endtask

   task automatic lookup(input bit ir, input logic [31:0] ia, input bit dr,
                         input logic [31:0] da, input bit dw);
      drive_lookup(ir, ia, dr, da, dw);
      cyc();
      check_lookup("lookup");
      ireq = 0; dreq = 0; dwrite = 0;
   endtask

   // Runs one CP0 op; a lookup driven during EXEC must see the pre-write table.
   task automatic do_op(input logic [1:0] opc, input logic [3:0] idx, input logic [31:0] hi,
                        input logic [31:0] lo0, input logic [31:0] lo1, input bit ir,
                        input logic [31:0] ia, output logic [3:0] tgt);
      entryhi = hi; entrylo0 = lo0; entrylo1 = lo1; index_in = idx; op = opc;
      chk("op_ready_idle", 32'(op_ready), 32'd1);
      op_valid = 1;
      cyc();
      op_valid = 0;
      chk("op_ready_exec", 32'(op_ready), 32'd0);
      chk("op_done_exec", 32'(op_done), 32'd0);
      chk("random_exec", 32'(random_out), 32'(m_rand));
      tgt = (opc == 2'b11) ? m_rand : idx;
      drive_lookup(ir, ia, ir, ia ^ 32'h0000_1000, 1'b1);
      cyc();
      chk("op_done", 32'(op_done), 32'd1);
      check_lookup("op_lookup");
      ireq = 0; dreq = 0; dwrite = 0;
      case (opc)
         2'b00: e_index = model_probe(hi);
         2'b01: begin
            e_ehi = {m_hi[idx][31:13], 5'b0, m_hi[idx][7:0]};
            e_lo0 = {6'b0, m_lo0[idx][25:1], m_lo0[idx][0] & m_lo1[idx][0]};
            e_lo1 = {6'b0, m_lo1[idx][25:1], m_lo0[idx][0] & m_lo1[idx][0]};
         end
         default: begin
            m_valid[tgt] = 1; m_hi[tgt] = hi; m_lo0[tgt] = lo0; m_lo1[tgt] = lo1;
         end
      endcase
      chk("index_o", index_out, e_index);
      chk("entryhi_o", entryhi_out, e_ehi);
      chk("entrylo0_o", lo0_out, e_lo0);
      chk("entrylo1_o", lo1_out, e_lo1);
      cyc();
      chk("op_done_clear", 32'(op_done), 32'd0);
      chk("op_ready_back", 32'(op_ready), 32'd1);
   endtask

   logic [18:0] vset [4];
   logic [3:0]  t;
   logic [31:0] va_r, hi_r;
   logic [1:0]  opc_r;
   logic [3:0]  idx_r;

   initial begin
      vset[0] = 19'h00200; vset[1] = 19'h00201; vset[2] = 19'h00400; vset[3] = 19'h08000;
      for (int k = 0; k < N; k++) begin
         m_valid[k] = 0; m_hi[k] = 0; m_lo0[k] = 0; m_lo1[k] = 0;
      end

      // reset state
      cyc(); cyc();
      chk("rst_ready", 32'(op_ready), 32'd1);
      chk("rst_done", 32'(op_done), 32'd0);
      chk("rst_random", 32'(random_out), 32'd15);
      chk("rst_index", index_out, 32'd0);
      check_lookup("rst");
      rst = 0;

      // empty TLB miss
      entryhi = 32'h0040_0005;
      lookup(1, 32'h0040_0000, 0, 0, 0);
      chk("empty_ipa", ipa, 32'd0);

      // TLBWI idx 3, then even/odd translation
      do_op(2'b10, 4'd3, 32'h0040_0005, 32'h0000_0482, 32'h0000_0D06, 1, 32'h0040_0ABC, t);
      lookup(1, 32'h0040_0ABC, 1, 32'h0040_1ABC, 0);
      chk("dir_ihit", 32'(ihit), 32'd1);
      chk("dir_ipa", ipa, 32'h0001_2ABC);
      chk("dir_dpa", dpa, 32'h0003_4ABC);

      // ASID mismatch, then global rewrite
      entryhi = 32'h0040_0006;
      lookup(1, 32'h0040_0ABC, 0, 0, 0);
      chk("asid_miss", 32'(ihit), 32'd0);
      do_op(2'b10, 4'd3, 32'h0040_0006, 32'h0000_0483, 32'h0000_0D07, 0, 0, t);
      lookup(1, 32'h0040_0ABC, 0, 0, 0);
      chk("global_hit", 32'(ihit), 32'd1);

      // store to clean even page and dirty odd page
      lookup(0, 0, 1, 32'h0040_0123, 1);
      chk("dmod_even", 32'(dmod), 32'd1);
      lookup(0, 0, 1, 32'h0040_1123, 1);
      chk("dmod_odd", 32'(dmod), 32'd0);

      // TLBP hit/miss, TLBR
      do_op(2'b00, 4'd0, 32'h0040_0006, 0, 0, 0, 0, t);
      chk("tlbp_hit", index_out, 32'd3);
      do_op(2'b00, 4'd0, 32'h0080_0006, 0, 0, 0, 0, t);
      chk("tlbp_miss", index_out, 32'h8000_0000);
      do_op(2'b01, 4'd3, 32'h0040_0006, 0, 0, 0, 0, t);
      chk("tlbr_hi", entryhi_out, 32'h0040_0006);
      chk("tlbr_lo0", lo0_out, 32'h0000_0483);
      chk("tlbr_lo1", lo1_out, 32'h0000_0D07);

      // Wired = 4: Random walks down to 4 and reloads 15
      wired = 4'd4;
      for (int i = 0; i < 30; i++) begin
         cyc();
         chk("random_wired4", 32'(random_out), 32'(m_rand));
      end
      wired = 4'd15;
      cyc(); cyc();
      chk("random_hold", 32'(random_out), 32'd15);
      wired = 4'd4;

      // TLBWR lands on the sampled Random value
      do_op(2'b11, 4'd0, 32'h0080_0005, 32'h0000_0F42, 32'h0000_1F46, 0, 0, t);
      do_op(2'b01, t, 32'h0080_0005, 0, 0, 0, 0, t);
      chk("tlbwr_hi", entryhi_out, 32'h0080_0005);
      entryhi = 32'h0080_0005;
      lookup(1, 32'h0080_0010, 0, 0, 0);
      chk("tlbwr_ipa", ipa, 32'h0003_D010);

      // randomized ops and lookups
      wired = 4'd2;
      for (int i = 0; i < 60; i++) begin
         va_r = {vset[$urandom_range(0, 3)], 13'($urandom)};
         hi_r = {vset[$urandom_range(0, 3)], 5'($urandom), ($urandom_range(0, 1) ? 8'd5 : 8'd6)};
         if ($urandom_range(0, 1) == 0) begin
            opc_r = 2'($urandom);
            idx_r = 4'($urandom);
            if (opc_r == 2'b01 && !m_valid[idx_r]) opc_r = 2'b00;
            do_op(opc_r, idx_r, hi_r, $urandom, $urandom, 1, va_r, t);
         end else begin
            entryhi = hi_r;
            lookup($urandom_range(0, 1), va_r, $urandom_range(0, 1),
                   {vset[$urandom_range(0, 3)], 13'($urandom)}, $urandom_range(0, 1));
         end
         chk("random_rand", 32'(random_out), 32'(m_rand));
      end

      // reset in the middle of EXEC aborts the write
      wired = 4'd0;
      entryhi = 32'h0040_0005; entrylo0 = 32'h0000_0482; entrylo1 = 32'h0000_0D06;
      index_in = 4'd7; op = 2'b10; op_valid = 1;
      cyc();
      op_valid = 0;
      chk("abort_exec", 32'(op_ready), 32'd0);
      rst = 1;
      #1;
      chk("abort_ready", 32'(op_ready), 32'd1);
      chk("abort_done", 32'(op_done), 32'd0);
      chk("abort_random", 32'(random_out), 32'd15);
      for (int k = 0; k < N; k++) m_valid[k] = 0;
      e_ihit = 0; e_ipa = 0; e_iflags = 0; e_dhit = 0; e_dpa = 0; e_dflags = 0; e_dmod = 0;
      e_ehi = 0; e_lo0 = 0; e_lo1 = 0; e_index = 0;
      @(negedge clk);
      rst = 0;
      cyc();
      chk("abort_no_pulse", 32'(op_done), 32'd0);
      lookup(1, 32'h0040_0ABC, 1, 32'h0040_1ABC, 0);
      chk("abort_miss", 32'(ihit), 32'd0);
      do_op(2'b00, 4'd0, 32'h0040_0005, 0, 0, 0, 0, t);
      chk("abort_probe", index_out, 32'h8000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tlb_mmu.md
Name: tlb_mmu

Overview:
- Parametrised, fully associative joint TLB. Successor to the fixed 16-entry JTLB.
- Serves two registered lookup channels: instruction and data.
- Executes CP0 TLB operations (TLBP, TLBR, TLBWI, TLBWR) through a small valid/ready sequencer.
- Maintains the MIPS Random register with Wired support. Sits between the CP0 block and the fetch/memory stages of the core.

Parameters:
- NUM_ENTRIES, 16, number of TLB entries; power of two, 4..64.
- ASID_W, 8, ASID width held per entry.
- PFN_W, 20, physical frame number width; 4 KB pages, even/odd pair per entry.
- IDX_W is a localparam equal to clog2(NUM_ENTRIES).

Ports:
- clk_i in 1 system clock
- rst_i in 1 reset; asynchronous, active-high
- ireq_i in 1 instruction lookup request
- iva_i in 32 instruction virtual address
- ihit_o out 1 registered instruction hit
- ipa_o out 32 registered instruction physical address
- iflags_o out 5 registered {C[2:0],D,V}
- dreq_i in 1 data lookup request
- dva_i in 32 data virtual address
- dwrite_i in 1 data access is a store
- dhit_o out 1 registered data hit
- dpa_o out 32 registered data physical address
- dflags_o out 5 registered {C[2:0],D,V}
- dmod_o out 1 registered TLB-modified condition
- op_valid_i in 1 CP0 operation request
- op_i in 2 00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- op_ready_o out 1 sequencer idle
- op_done_o out 1 one-cycle completion pulse
- entryhi_i in 32 {VPN2[31:13],ASID[ASID_W-1:0]}
- entrylo0_i in 32 {PFN[25:6],C[5:3],D[2],V[1],G[0]}
- entrylo1_i in 32 same format, odd page
- index_i in IDX_W target index for TLBWI/TLBR
- wired_i in IDX_W Wired register value
- entryhi_o out 32 TLBR result
- entrylo0_o out 32 TLBR result; G replicated
- entrylo1_o out 32 TLBR result; G replicated
- index_o out 32 TLBP result: bit31 = P (miss), low IDX_W bits = matching index
- random_o out IDX_W Random register

Behaviour:
- Reset (async, rst_i=1):
  - All entry valid bits cleared.
  - Sequencer returns to IDLE.
  - All registered outputs are 0, except random_o = NUM_ENTRIES-1 and op_ready_o = 1.
  - Entry contents are unaffected (don't care).
  - Reset during EXEC aborts the operation; no write occurs and no done pulse is issued.
- Match rule for entry k:
  - valid[k] && VPN2[k]==va[31:13] && (G[k] || ASID[k]==entryhi_i ASID).
  - With multiple matches, the lowest index wins.
- Lookup latency is 1 cycle. Outputs update only on cycles where the request is high; otherwise they hold.
  - On a hit: PA = {PFN(va[12] ? lo1 : lo0), va[11:0]}; flags come from the selected half.
  - On a miss: hit=0, pa=0, flags=0.
  - hit=1 with V=0 is legal; the consumer raises TLB-invalid.
  - dmod_o = dwrite_i && hit && V && !D.
- Sequencer states:
  - IDLE: op_ready_o=1. op_valid_i latches op_i and goes to EXEC.
  - EXEC: one cycle; performs the operation.
  - DONE: op_done_o=1 for one cycle, then back to IDLE.
  - op_valid_i is ignored outside IDLE.
- Operations:
  - TLBP: compares entryhi_i against all entries. index_o = {1'b0, idx} on a match, else 32'h8000_0000. index_o is registered at the end of EXEC.
  - TLBR: entryhi_o/entrylo0_o/entrylo1_o are loaded from entry index_i at the end of EXEC. Unused bits are 0.
  - TLBWI: writes entry index_i at the end of EXEC and sets its valid bit. G = lo0.G & lo1.G.
  - TLBWR: same as TLBWI, but the target is the random_o value sampled at the start of EXEC.
- Write/lookup collision: a lookup in the same cycle as a write sees the old contents. The written entry is visible to lookups from the next cycle.
- Random register:
  - Decrements every cycle.
  - When it equals wired_i (or is below it), the next value is NUM_ENTRIES-1.
  - If wired_i >= NUM_ENTRIES-1, it holds at NUM_ENTRIES-1.
  - A completed TLBWR does not reset it.

Decomposition:
- Package tlb_pkg holds:
  - op encodings (TLBP/TLBR/TLBWI/TLBWR);
  - EntryLo field bit positions;
  - the sequencer state encoding;
  - the entry struct {vpn2, asid, g, valid, pfn0, flags0, pfn1, flags1}.
- One sub-module: tlb_match. It is a combinational priority matcher (NUM_ENTRIES compare plus priority encode) with outputs {match, index}. It is instantiated three times: instruction, data and probe.

Test Plan:
- Reset, then ireq with iva=0x0040_0000 → next cycle ihit_o=0, ipa_o=0; random_o=15 after reset.
- TLBWI at idx 3 with entryhi=0x0040_0005, lo0 PFN=0x12 V=1 G=0, lo1 PFN=0x34 V=1 D=1 → op_done_o pulses 2 cycles after op_valid_i.
  - Then iva=0x0040_0ABC gives ihit=1, ipa=0x0001_2ABC.
  - dva=0x0040_1ABC gives dpa=0x0003_4ABC.
- Same mapping, ASID changed to 6 → miss. Rewrite with lo0.G=lo1.G=1 → hit with ASID 6.
- Store to the even page (D=0) → dhit=1, dmod_o=1. Store to the odd page (D=1) → dmod_o=0.
- TLBP on a mapped VPN2 → index_o=3. TLBP on an unmapped VPN2 → index_o=0x8000_0000. TLBR idx 3 returns the written fields with unused bits 0.
- wired_i=4: random_o cycles 15..4 and wraps to 15.
  - TLBWR writes the sampled index.
  - Assert rst_i mid-EXEC → no write, entries invalid, op_ready_o=1.
